// File: rtl/cohort_mem_pkg.sv
// Shared types and constants for the cohort memory responder: request encodings,
// FSM state type and bus widths.
package cohort_mem_pkg;

  localparam int WORD_W     = 64;
  localparam int MASK_W     = WORD_W / 8;
  localparam int REQ_TYPE_W = 8;
  localparam int MSHRID_W   = 8;
  localparam int ADDR_W     = 40;
  localparam int SIZE_W     = 3;
  localparam int HOMEID_W   = 16;

  // Values follow the NoC2 message-type field so the arbiter's encoding passes through untouched.
  typedef enum logic [REQ_TYPE_W-1:0] {
    AMO_CAS  = 8'd5,
    AMO_SWAP = 8'd9,
    LOAD     = 8'd19,
    STORE    = 8'd20,
    AMO_ADD  = 8'd36
  } req_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RMW  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic is_amo(input logic [REQ_TYPE_W-1:0] t);
    return (t == AMO_ADD) || (t == AMO_SWAP) || (t == AMO_CAS);
  endfunction

endpackage

// File: rtl/cohort_mem_if.sv
// Request and response bundles between the cohort MSHR NoC arbiter and the memory responder.
// Request handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the master holds all fields stable while valid=1 and ready=0. The response channel has
// no ready: valid is a single-cycle pulse and mshrid/data read 0 whenever valid=0.
interface mem_req_if;
  import cohort_mem_pkg::*;
  logic                  valid;
  logic                  ready;
  logic [REQ_TYPE_W-1:0] req_type;
  logic [MSHRID_W-1:0]   mshrid;
  logic [ADDR_W-1:0]     address;
  logic [SIZE_W-1:0]     size;
  logic [HOMEID_W-1:0]   homeid;
  logic [MASK_W-1:0]     write_mask;
  logic [WORD_W-1:0]     data_0;
  logic [WORD_W-1:0]     data_1;

  modport master (output valid, req_type, mshrid, address, size, homeid, write_mask,
                  data_0, data_1, input ready);
  modport slave  (input valid, req_type, mshrid, address, size, homeid, write_mask,
                  data_0, data_1, output ready);
endinterface

interface atomic_resp_if;
  import cohort_mem_pkg::*;
  logic                valid;
  logic [MSHRID_W-1:0] mshrid;
  logic [WORD_W-1:0]   data;

  modport master (output valid, mshrid, data);
  modport slave  (input valid, mshrid, data);
endinterface

// File: rtl/cohort_mem_array.sv
// Backing store: asynchronous read port plus byte-masked synchronous write port.
// A read and write to the same word in one cycle returns the pre-write value.
module cohort_mem_array
  import cohort_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [MASK_W-1:0] wr_be,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cohort_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY cycles,
// optionally performs an atomic read-modify-write, then pulses a response.
module cohort_mem_responder
  import cohort_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_req_if.slave             mem_req,
  atomic_resp_if.master        atomic_resp,
  output state_t               dbg_state
);

  localparam int IDX_W          = $clog2(DEPTH_WORDS);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [REQ_TYPE_W-1:0] type_q;
  logic [MSHRID_W-1:0]   mshrid_q;
  logic [IDX_W-1:0]      idx_q;
  logic [MASK_W-1:0]     mask_q;
  logic [WORD_W-1:0]     d0_q, d1_q;
  logic [WORD_W-1:0]     resp_data_q, resp_data_d;

  logic                  accept;
  logic [WORD_W-1:0]     old_word;
  logic                  wr_en, wr_en_gated;
  logic [MASK_W-1:0]     wr_be;
  logic [WORD_W-1:0]     wr_data;
  logic                  unused_req_bits;

  assign mem_req.ready = rst_n && (state_q == ST_IDLE);
  assign accept        = mem_req.valid && mem_req.ready;

  // size, homeid and the address bits outside the word index carry no meaning here.
  assign unused_req_bits = ^{mem_req.size, mem_req.homeid, mem_req.address};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    wr_en       = 1'b0;
    wr_be       = '0;
    wr_data     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          if (is_amo(type_q)) begin
            state_d = ST_RMW;
          end else begin
            state_d = ST_RESP;
            if (type_q == STORE) begin
              // Committing on the edge into RESP makes the store visible to the next request.
              wr_en       = 1'b1;
              wr_be       = mask_q;
              wr_data     = d0_q;
              resp_data_d = '0;
            end else begin
              resp_data_d = old_word;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RMW: begin
        state_d     = ST_RESP;
        resp_data_d = old_word;
        wr_be       = '1;
        case (type_q)
          AMO_ADD: begin
            wr_en   = 1'b1;
            wr_data = old_word + d0_q;
          end
          AMO_SWAP: begin
            wr_en   = 1'b1;
            wr_data = d0_q;
          end
          AMO_CAS: begin
            wr_en   = (old_word == d0_q);
            wr_data = d1_q;
          end
          default: ;
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write landing on a reset edge belongs to a discarded transaction.
  assign wr_en_gated = wr_en && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      mshrid_q    <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      if (accept) begin
        type_q   <= mem_req.req_type;
        mshrid_q <= mem_req.mshrid;
        idx_q    <= mem_req.address[3 +: IDX_W];
        mask_q   <= mem_req.write_mask;
        d0_q     <= mem_req.data_0;
        d1_q     <= mem_req.data_1;
      end
    end
  end

  cohort_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .rd_idx  (idx_q),
    .rd_data (old_word),
    .wr_en   (wr_en_gated),
    .wr_idx  (idx_q),
    .wr_be   (wr_be),
    .wr_data (wr_data)
  );

  assign atomic_resp.valid  = (state_q == ST_RESP);
  assign atomic_resp.mshrid = atomic_resp.valid ? mshrid_q : '0;
  assign atomic_resp.data   = atomic_resp.valid ? resp_data_q : '0;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_cohort_mem_responder.sv
// Directed bench for cohort_mem_responder: a memory model predicts every response and
// its cycle, and a negedge monitor pops and checks them.
module tb_cohort_mem_responder;
  import cohort_mem_pkg::*;

  localparam int D     = 1024;
  localparam int L     = 4;
  localparam int IDX_W = $clog2(D);
  localparam int EXP_W = 32 + MSHRID_W + WORD_W;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  mem_req_if     req_bus ();
  atomic_resp_if resp_bus ();

  cohort_mem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (req_bus),
    .atomic_resp (resp_bus),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit busy   = 1'b0;
  logic [EXP_W-1:0]  exp_q[$];
  logic [WORD_W-1:0] model_mem [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the head of the expected queue at its cycle.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (mon_en) begin
      if (busy) chk("ready_while_busy", 64'(req_bus.ready), 64'd0);
      if (resp_bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("resp_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_mshrid", 64'(resp_bus.mshrid), 64'(e[WORD_W +: MSHRID_W]));
          chk("resp_data", resp_bus.data, e[WORD_W-1:0]);
          chk("resp_cycle", 64'(cyc), 64'(e[WORD_W+MSHRID_W +: 32]));
        end
        busy = 1'b0;
      end else begin
        chk("idle_mshrid", 64'(resp_bus.mshrid), 64'd0);
        chk("idle_data", resp_bus.data, 64'd0);
      end
    end
  end

  task automatic idle();
    req_bus.valid = 1'b0;
  endtask

  // Presents a request and returns on the negedge after acceptance with valid still high.
  task automatic send(input logic [7:0] t, input logic [ADDR_W-1:0] addr, input logic [7:0] mask,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [7:0] id,
                      input bit expect_resp);
    int waited = 0;
    int idx;
    logic [63:0] old, nw, rdat;
    bit amo;
    req_bus.valid      = 1'b1;
    req_bus.req_type   = t;
    req_bus.address    = addr;
    req_bus.write_mask = mask;
    req_bus.data_0     = d0;
    req_bus.data_1     = d1;
    req_bus.mshrid     = id;
    req_bus.size       = 3'(($urandom_range(0, 7)));
    req_bus.homeid     = 16'($urandom_range(0, 65535));
    #1;
    while (req_bus.ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (req_bus.ready !== 1'b1) begin
      chk("accept_timeout", 64'(waited), 64'd0);
      idle();
      return;
    end
    idx  = int'(addr[3 +: IDX_W]);
    old  = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
    nw   = old;
    rdat = old;
    amo  = 1'b0;
    case (t)
      STORE: begin
        rdat = 64'h0;
        for (int b = 0; b < 8; b++) if (mask[b]) nw[8*b +: 8] = d0[8*b +: 8];
      end
      AMO_ADD:  begin amo = 1'b1; nw = old + d0; end
      AMO_SWAP: begin amo = 1'b1; nw = d0; end
      AMO_CAS:  begin amo = 1'b1; if (old == d0) nw = d1; end
      default: ;
    endcase
    if (expect_resp) begin
      if (t == STORE || amo) model_mem[idx] = nw;
      exp_q.push_back({32'(cyc + L + 1 + (amo ? 1 : 0)), id, rdat});
    end
    busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || busy) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    req_bus.valid = 1'b0; req_bus.req_type = '0; req_bus.mshrid = '0; req_bus.address = '0;
    req_bus.size = '0; req_bus.homeid = '0; req_bus.write_mask = '0;
    req_bus.data_0 = '0; req_bus.data_1 = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_ready", 64'(req_bus.ready), 64'd0);
    chk("rst_valid", 64'(resp_bus.valid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(req_bus.ready), 64'd1);

    // Store then load back.
    send(STORE, 40'h40, 8'hFF, 64'h1122334455667788, 64'h0, 8'd130, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    send(LOAD, 40'h40, 8'h00, 64'h0, 64'h0, 8'd131, 1'b1);
    idle();

    // AMO_ADD wraps modulo 2^64.
    send(STORE, 40'h80, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'd1, 1'b1);
    send(AMO_ADD, 40'h80, 8'h00, 64'h2, 64'h0, 8'd2, 1'b1);
    send(LOAD, 40'h80, 8'h00, 64'h0, 64'h0, 8'd3, 1'b1);
    idle();

    // CAS hit then miss.
    send(STORE, 40'hC0, 8'hFF, 64'h5, 64'h0, 8'd4, 1'b1);
    send(AMO_CAS, 40'hC0, 8'h00, 64'h5, 64'h9, 8'd5, 1'b1);
    send(AMO_CAS, 40'hC0, 8'h00, 64'h5, 64'h7, 8'd6, 1'b1);
    send(LOAD, 40'hC0, 8'h00, 64'h0, 64'h0, 8'd7, 1'b1);

    // Partial-mask store, requests presented back-to-back with valid held high.
    send(STORE, 40'h0, 8'hFF, 64'h0, 64'h0, 8'd8, 1'b1);
    send(STORE, 40'h0, 8'h0F, 64'hAAAAAAAABBBBBBBB, 64'h0, 8'd9, 1'b1);
    send(LOAD, 40'h0, 8'h00, 64'h0, 64'h0, 8'd10, 1'b1);

    // Swap, then an unknown opcode behaves as a load without writing.
    send(AMO_SWAP, 40'h80, 8'h00, 64'hDEADBEEFCAFEF00D, 64'h0, 8'd11, 1'b1);
    send(8'hEE, 40'h80, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 8'd12, 1'b1);
    send(LOAD, 40'h80, 8'h00, 64'h0, 64'h0, 8'd13, 1'b1);
    idle();

    // High address bits alias onto word 2.
    send(STORE, 40'(D * 8 + 'h10), 8'hFF, 64'h0F0E0D0C0B0A0908, 64'h0, 8'd14, 1'b1);
    send(LOAD, 40'h10, 8'h00, 64'h0, 64'h0, 8'd15, 1'b1);
    idle();

    // Randomised mix over preset words 0..3.
    send(STORE, 40'h8, 8'hFF, 64'h0, 64'h0, 8'd16, 1'b1);
    send(STORE, 40'h18, 8'hFF, 64'h3333333333333333, 64'h0, 8'd17, 1'b1);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] t;
      case ($urandom_range(0, 4))
        0: t = LOAD;
        1: t = STORE;
        2: t = AMO_ADD;
        3: t = AMO_SWAP;
        default: t = AMO_CAS;
      endcase
      w = {$urandom, $urandom};
      send(t, 40'($urandom_range(0, 3) * 8), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 1) == 1) ? model_mem[0] : w, {$urandom, $urandom},
           8'(20 + i), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    drain();

    // Reset during WAIT of an AMO_SWAP discards it completely.
    send(AMO_SWAP, 40'h18, 8'h00, 64'h5555555555555555, 64'h0, 8'd99, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_bus.ready), 64'd0);
    @(negedge clk);
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst_valid", 64'(resp_bus.valid), 64'd0);
    busy  = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 64'(req_bus.ready), 64'd1);
    repeat (L + 4) @(negedge clk);
    send(LOAD, 40'h18, 8'h00, 64'h0, 64'h0, 8'd100, 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: simulation did not complete, observed %0d expected 0", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
